// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module   : adder
// Purpose  : Registered unsigned adder, c = a + b on WIDTH+1 bits, with a
//            one-cycle c_valid strobe per accepted operand pair.
// Options  : ADDER_PIPE_EN - adds one register stage on the sum/valid path
//            (latency 2 instead of 1; same ports, reset values and math).
// Revision : 1.0 - initial release
// ============================================================================
module adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,      // asynchronous, active-low
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             valid,
  output logic [WIDTH:0]   c,
  output logic             c_valid
);

  localparam int SUM_W = WIDTH + 1;

  // Zero-extended sum; the extra bit absorbs the carry so nothing wraps.
  logic [SUM_W-1:0] sum;

  // Operands only matter when valid qualifies them; the registers below
  // ignore sum otherwise, so unqualified operand values never reach c.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
  end

`ifdef ADDER_PIPE_EN

  // First stage: sum and its qualifier, held like the output stage.
  logic [SUM_W-1:0] s1_sum;
  logic             s1_vld;

  // Stage 1 capture: take a new sum only on a qualified cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_sum <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= valid;
      if (valid) begin
        s1_sum <= sum;
      end
    end
  end

  // Output stage: present the stage-1 result, hold c when nothing new arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c       <= '0;
      c_valid <= 1'b0;
    end else begin
      c_valid <= s1_vld;
      if (s1_vld) begin
        c <= s1_sum;
      end
    end
  end

`else

  // Single stage: capture the sum on a qualified edge, otherwise hold c and
  // drop the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c       <= '0;
      c_valid <= 1'b0;
    end else begin
      c_valid <= valid;
      if (valid) begin
        c <= sum;
      end
    end
  end

`endif

endmodule
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder
// Purpose  : Scoreboard bench for adder (WIDTH=4). Stimulus pushes expected
//            sums into a queue; a monitor pops and compares on each c_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder;

  localparam int WIDTH = 4;
`ifdef ADDER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             valid;
  logic [WIDTH:0]   c;
  logic             c_valid;

  int checks = 0;
  int errors = 0;

  logic [WIDTH:0] sb[$];

  adder #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .valid  (valid),
    .c      (c),
    .c_valid(c_valid)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one qualified operand pair and record its expected sum.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [WIDTH:0] exp);
    @(posedge clk);
    #1;
    a     = x;
    b     = y;
    valid = 1'b1;
    sb.push_back(exp);
  endtask

  task automatic idle(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(posedge clk);
    #1;
    a     = x;
    b     = y;
    valid = 1'b0;
  endtask

  // Monitor: every c_valid must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (c_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_c_valid", {{WIDTH{1'b0}}, c_valid}, '0);
        end else begin
          check("sum", c, sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst   = 1'b0;
    a     = 4'd5;
    b     = 4'd3;
    valid = 1'b1;

    // Reset held with live inputs: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_c", c, '0);
      check("reset_c_valid", {{WIDTH{1'b0}}, c_valid}, '0);
    end
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;

    // Basic add followed by hold with changing, unqualified operands.
    issue(4'd5, 4'd3, 5'd8);
    for (int i = 0; i < LAT + 4; i++) begin
      idle(4'd9, 4'd9);
      if (i >= LAT) begin
        check("hold_c", c, 5'd8);
        check("hold_c_valid", {{WIDTH{1'b0}}, c_valid}, '0);
      end
    end

    // Operand extremes.
    issue(4'd15, 4'd15, 5'd30);
    issue(4'd0, 4'd0, 5'd0);
    idle(4'd0, 4'd0);

    // Back-to-back stream, including a carry-out case.
    issue(4'd1, 4'd2, 5'd3);
    issue(4'd7, 4'd9, 5'd16);
    issue(4'd15, 4'd1, 5'd16);
    issue(4'd10, 4'd6, 5'd16);
    issue(4'd12, 4'd9, 5'd21);
    for (int i = 0; i < LAT + 2; i++) idle(4'd3, 4'd3);

    // Leave a known nonzero result so the reset clear is observable.
    issue(4'd6, 4'd5, 5'd11);
    for (int i = 0; i < LAT + 2; i++) idle(4'd0, 4'd0);
    check("pre_reset_c", c, 5'd11);

    // Mid-operation reset: the in-flight pair must vanish without a strobe.
    issue(4'd2, 4'd2, 5'd4);
    for (int i = 0; i < LAT - 1; i++) begin
      @(posedge clk);
      #1;
      valid = 1'b0;
    end
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    check("async_clear_c", c, '0);
    check("async_clear_c_valid", {{WIDTH{1'b0}}, c_valid}, '0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < LAT + 3; i++) idle(4'd2, 4'd2);
    check("post_reset_c", c, '0);

    // First capture after reset release.
    issue(4'd4, 4'd9, 5'd13);
    idle(4'd0, 4'd0);

    // Drain the scoreboard within a bounded number of cycles.
    begin
      int budget;
      budget = 20;
      while (sb.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      end
    end
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 The adder SHALL have parameter WIDTH, default 4, giving the bit width of operands a and b.
REQ-002 The adder SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 The adder SHALL have port rst, input, 1 bit, the reset; reset is asynchronous and active-low.
REQ-004 The adder SHALL have port a, input, WIDTH bits, unsigned operand A.
REQ-005 The adder SHALL have port b, input, WIDTH bits, unsigned operand B.
REQ-006 The adder SHALL have port valid, input, 1 bit, which qualifies a and b in the current cycle.
REQ-007 The adder SHALL have port c, output, WIDTH+1 bits, the registered unsigned sum a+b.
REQ-008 The adder SHALL have port c_valid, output, 1 bit, which is high for exactly the cycle in which c presents a new result.

Function
REQ-009 The adder SHALL form the sum as a zero-extended (WIDTH+1)-bit addition, a+b; no overflow or wrap is possible, and the maximum result is 2^(WIDTH+1)-2.
REQ-010 The adder SHALL capture a and b on a rising clk edge where valid=1, with c and c_valid updated at that same edge (latency 1 cycle in the base build).
REQ-011 The adder SHALL hold c at its last value on an edge where valid=0, and SHALL drive c_valid=0 for that cycle.
REQ-012 The adder SHALL accept valid asserted on back-to-back cycles, producing one result per cycle in order, with no stall and no backpressure.
REQ-013 The adder SHALL ignore a and b entirely while valid=0, so that X or changing operands do not affect c.
REQ-014 The adder SHALL drive c and c_valid only from registers, with no combinational path from the inputs to the outputs.

Reset
REQ-015 When rst=0, the adder SHALL immediately and asynchronously clear c to 0, c_valid to 0, and all internal pipeline registers.
REQ-016 The adder SHALL leave reset synchronously, so the first capture occurs on the first rising clk edge with rst=1 and valid=1.
REQ-017 A reset asserted mid-operation SHALL discard any in-flight result; no c_valid pulse for that result SHALL appear after reset is released.

Configuration
REQ-018 When macro ADDER_PIPE_EN is defined, the adder SHALL add one extra register stage on the sum and valid path, giving a latency of 2 cycles, a throughput of 1 per cycle, and a c hold/valid rule identical to the base build applied at the output stage.
REQ-019 When ADDER_PIPE_EN is not defined, the adder SHALL have a latency of exactly 1 cycle as in REQ-010.
REQ-020 The ADDER_PIPE_EN option SHALL NOT change the port list, reset values or arithmetic.

Verification
REQ-021 Reset: drive rst=0 while clk is running with a=5, b=3, valid=1 -> c=0 and c_valid=0 throughout reset, including immediately at assertion.
REQ-022 Basic add: a=5, b=3, valid=1 for one cycle -> c=8 and c_valid=1 after the build latency, after which c holds at 8 with c_valid=0.
REQ-023 Maximum operands: a=15, b=15 (WIDTH=4) -> c=30 (5'b11110); a=0, b=0 -> c=0.
REQ-024 Streaming: valid=1 on 3 consecutive cycles with (1,2), (7,9), (15,1) -> c sequence 3, 16, 16 on consecutive cycles, with c_valid high for 3 cycles.
REQ-025 Hold: after c=8, drive valid=0 with a=9, b=9 for 4 cycles -> c stays 8 and c_valid stays 0.
REQ-026 Mid-operation reset: under ADDER_PIPE_EN, assert valid=1 with a=2, b=2, then pulse rst=0 before the result emerges -> no c_valid pulse, and c=0 after reset.
